// File: rtl/fetch_unit_if.sv
// Fetch unit bus: ROM port, decoder feedback and fetch outputs.
// FETCH_HALT_EN adds the halted signal to both modports.
interface fetch_unit_if;
    logic [7:0] romData;
    logic [7:0] romAddr;
    logic [7:0] dbus;
    logic       doJumpBar;
    logic       denyFetch;
    logic [7:0] ir;
    logic [7:0] pc;
    logic       execute;
`ifdef FETCH_HALT_EN
    logic       halted;

    modport master (
        input  romData, dbus, doJumpBar, denyFetch,
        output romAddr, ir, pc, execute, halted
    );

    modport slave (
        output romData, dbus, doJumpBar, denyFetch,
        input  romAddr, ir, pc, execute, halted
    );
`else
    modport master (
        input  romData, dbus, doJumpBar, denyFetch,
        output romAddr, ir, pc, execute
    );

    modport slave (
        output romData, dbus, doJumpBar, denyFetch,
        input  romAddr, ir, pc, execute
    );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch / program counter with a FETCH/EXEC two-state FSM.
// Optional jump-to-self halt is enabled by defining FETCH_HALT_EN.
module fetch_unit (
    input  logic         clk,
    input  logic         resetBar,
    fetch_unit_if.master bus
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_instr_addr;
    logic [7:0] w_pc_inc;
    logic       w_freeze;
    logic       w_ir_en;

    assign w_pc_inc = r_pc + 8'd1;

`ifdef FETCH_HALT_EN
    logic r_halted;
    logic w_halt_hit;

    assign w_halt_hit = (r_state == S_EXEC) & ~bus.doJumpBar
                      & (bus.dbus == r_instr_addr);

    // Sticky halt: set on a jump back to the current instruction
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            r_halted <= 1'b0;
        end else if (w_halt_hit) begin
            r_halted <= 1'b1;
        end
    end

    assign w_freeze   = r_halted | w_halt_hit;
    assign w_ir_en    = (r_state == S_EXEC) & ~r_halted;
    assign bus.halted = r_halted;
`else
    assign w_freeze = 1'b0;
    assign w_ir_en  = (r_state == S_EXEC);
`endif

    // Fetch FSM: latch instructions, skip immediates, load jump targets
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            r_state      <= S_FETCH;
            r_pc         <= 8'h00;
            r_ir         <= 8'h00;
            r_instr_addr <= 8'h00;
        end else if (!w_freeze) begin
            unique case (r_state)
                S_FETCH: begin
                    r_ir         <= bus.romData;
                    r_instr_addr <= r_pc;
                    r_pc         <= w_pc_inc;
                    r_state      <= S_EXEC;
                end
                S_EXEC: begin
                    if (!bus.doJumpBar) begin
                        r_pc    <= bus.dbus;
                        r_state <= S_FETCH;
                    end else if (bus.denyFetch) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_FETCH;
                    end else begin
                        r_ir         <= bus.romData;
                        r_instr_addr <= r_pc;
                        r_pc         <= w_pc_inc;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // The bubble cycle presents NOP so the decoder does nothing
    assign bus.ir      = w_ir_en ? r_ir : 8'h00;
    assign bus.pc      = r_pc;
    assign bus.romAddr = r_pc;
    assign bus.execute = (r_state == S_EXEC);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter block feeding the control decoder. It owns the 8-bit program counter, addresses the program ROM and latches instruction bytes into the instruction register. It presents `ir` to the decoder and reacts to the decoder's `doJumpBar` and `denyFetch` on the following edge: it skips immediate operands, loads jump targets from the data bus, and inserts a refetch bubble.

## Interface
- No parameters; all widths are fixed at 8 bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetBar`  in  1  asynchronous, active-low reset.
- `romData`  in  8  byte read from program ROM at `romAddr`; combinational, valid within the same cycle.
- `romAddr`  out  8  program ROM address; equals `pc`.
- `dbus`  in  8  data bus; carries the jump target whenever `doJumpBar` is low.
- `doJumpBar`  in  1  from decoder; low means take a jump this cycle.
- `denyFetch`  in  1  from decoder; high means the ROM byte at `pc` must not be latched as the next instruction.
- `ir`  out  8  instruction presented to the decoder.
- `pc`  out  8  current program counter.
- `execute`  out  1  high in EXEC state.
- `halted`  out  1  only when `FETCH_HALT_EN` is defined; otherwise the port is absent.

## Operation
- Registers:
  - `pc[7:0]`
  - `irReg[7:0]`
  - `instrAddr[7:0]`: address the current `irReg` was fetched from.
  - `state`: FETCH or EXEC.
- `ir` output:
  - In EXEC, `ir = irReg`.
  - In FETCH, `ir = 8'h00`. This is the NOP encoding: dest 0 and source 0 enable no load, no assert and no jump.
- FETCH, on the edge:
  - `irReg <= romData`, `instrAddr <= pc`, `pc <= pc+1`.
  - Go to EXEC.
- EXEC, on the edge, priority order:
  1. `doJumpBar==0`: `pc <= dbus`; `irReg` unchanged; go to FETCH.
  2. `denyFetch==1` (immediate operand consumed): `pc <= pc+1`; go to FETCH.
  3. Otherwise (pipelined fetch): `irReg <= romData`, `instrAddr <= pc`, `pc <= pc+1`; stay in EXEC.
- Priority rules:
  - `doJumpBar` low wins regardless of `denyFetch`.
  - `doJumpBar` and `denyFetch` are ignored in FETCH.
- Arithmetic: `pc` increments modulo 256, so 8'hFF wraps to 8'h00 with no flag. A jump target of any value is legal.

## Timing
- Reset (asynchronous assert; release is synchronous to `clk`, with the first active edge after release): `pc=8'h00`, `irReg=8'h00`, `instrAddr=8'h00`, `state=FETCH`, `ir=8'h00`, `execute=0`, `halted=0`.
- The first instruction (ROM[0]) appears on `ir` one edge after reset release.
- Cost per instruction type:
  - Plain instruction: 1 cycle.
  - Immediate instruction: 2 cycles, made up of the execute cycle plus a refetch bubble.
  - Taken jump: 2 cycles.
  - Not-taken conditional jump: 1 cycle (`doJumpBar` high, `denyFetch` low).
- `romAddr` changes only after clock edges. `romData` must settle within the cycle, and the decoder outputs must settle before the next edge.
- Reset asserted mid-cycle forces reset values immediately, including from EXEC mid-jump. No partial update survives.

## Configuration
- `FETCH_HALT_EN` defined:
  - In EXEC with `doJumpBar==0` and `dbus==instrAddr` (jump-to-self), set `halted=1`.
  - Once halted, all registers freeze and `ir` is forced to 8'h00.
  - `halted` stays set until reset.
- `FETCH_HALT_EN` undefined: the `halted` port and its logic are absent. A jump-to-self loops forever at 2 cycles per iteration.

## Test plan
- Reset, then release with ROM[0]=8'h12 and ROM[1]=8'h34:
  - Cycle 0: `ir=8'h00`, `execute=0`.
  - Cycle 1: `ir=8'h12`, `pc=8'h01`.
  - Cycle 2: `ir=8'h34`, `pc=8'h02`.
- Immediate: with the instruction at 8'h05, hold `denyFetch=1`, `doJumpBar=1` for one EXEC cycle:
  - Next: `pc=8'h07`, FETCH, `ir=8'h00`.
  - Then: `ir=ROM[7]`, `pc=8'h08`.
- Jump: `doJumpBar=0`, `dbus=8'hA0` in EXEC:
  - Next: FETCH, `pc=8'hA0`.
  - Then: `ir=ROM[A0]`, `pc=8'hA1`.
- Wrap: jump to 8'hFF, where ROM[FF] is a plain instruction:
  - `ir=ROM[FF]`, `pc=8'h00`.
  - Next: `ir=ROM[00]`, `pc=8'h01`.
- Reset mid-operation: assert `resetBar=0` mid-cycle while `pc=8'h3C` in EXEC → immediately `pc=8'h00`, `ir=8'h00`, `execute=0`.
- `FETCH_HALT_EN`: instruction at 8'h10, `doJumpBar=0`, `dbus=8'h10` → `halted=1` next edge; `pc` is frozen and `ir=8'h00` for 10 further cycles.
